// File: rtl/button_step_gen.sv
// Push-button front end: 2-flop synchronizer, debounce FSM, one-cycle active-low
// step pulse per accepted press, optional auto-repeat while held.
module button_step_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_PERIOD   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  output logic       step_n,
  output logic       pressed,
  output logic [7:0] press_count
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W    = $clog2(REP_MAX + 1);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  logic            sync1_q, sync2_q;
  state_t          state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d, rep_lim;
  logic            rep_first_q, rep_first_d;
  logic            step_n_q, step_n_d;
  logic            pressed_q, pressed_d;
  logic [7:0]      press_count_q, press_count_d;

  // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; counter value before the pulse edge is lim.
  assign rep_lim = rep_first_q ? RP_W'(REPEAT_DELAY - 1) : RP_W'(REPEAT_PERIOD - 1);

  always_comb begin
    state_d       = state_q;
    db_cnt_d      = db_cnt_q;
    rep_cnt_d     = '0;
    rep_first_d   = 1'b1;
    step_n_d      = 1'b1;
    pressed_d     = pressed_q;
    press_count_d = press_count_q;
    case (state_q)
      RELEASED: begin
        pressed_d = 1'b0;
        if (!sync2_q) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = DB_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (sync2_q) begin
          state_d  = RELEASED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
          state_d       = HELD;
          db_cnt_d      = '0;
          step_n_d      = 1'b0;
          pressed_d     = 1'b1;
          press_count_d = press_count_q + 8'd1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      HELD: begin
        pressed_d = 1'b1;
        if (sync2_q) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = DB_W'(1);
        end else if (REPEAT_EN != 0) begin
          rep_first_d = rep_first_q;
          rep_cnt_d   = rep_cnt_q + 1'b1;
          if (rep_cnt_q == rep_lim) begin
            step_n_d    = 1'b0;
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
          end
        end
      end
      RELEASE_WAIT: begin
        if (!sync2_q) begin
          // Bounce back to held: no new pulse, repeat timing restarts from the delay.
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
          state_d   = RELEASED;
          db_cnt_d  = '0;
          pressed_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      state_q       <= RELEASED;
      db_cnt_q      <= '0;
      rep_cnt_q     <= '0;
      rep_first_q   <= 1'b1;
      step_n_q      <= 1'b1;
      pressed_q     <= 1'b0;
      press_count_q <= '0;
    end else begin
      sync1_q       <= btn_n;
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      rep_first_q   <= rep_first_d;
      step_n_q      <= step_n_d;
      pressed_q     <= pressed_d;
      press_count_q <= press_count_d;
    end
  end

  assign step_n      = step_n_q;
  assign pressed     = pressed_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_button_step_gen.sv
// Directed bench: one plain instance and one auto-repeat instance share clk/rst/btn_n.
module tb_button_step_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_n = 1'b1;
  logic       step0, pressed0, step1, pressed1;
  logic [7:0] cnt0, cnt1;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  button_step_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(0)) dut0 (
    .clk(clk), .rst(rst), .btn_n(btn_n), .step_n(step0), .pressed(pressed0), .press_count(cnt0));

  button_step_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut1 (
    .clk(clk), .rst(rst), .btn_n(btn_n), .step_n(step1), .pressed(pressed1), .press_count(cnt1));

  // Downstream xyz step FSM: advances one state per low cycle of step_n.
  logic [2:0] xyz;
  int         steps_seen;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xyz        <= 3'd0;
      steps_seen <= 0;
    end else if (!step0) begin
      xyz        <= xyz + 3'd1;
      steps_seen <= steps_seen + 1;
    end
  end

  logic prev_step0 = 1'b1;
  int   back_to_back = 0;
  always @(negedge clk) begin
    if (!rst && !step0 && !prev_step0) back_to_back++;
    prev_step0 <= rst ? 1'b1 : step0;
  end

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic btn;
    int   cycles;
    int   exp_lows;
    logic exp_pressed;
    int   exp_count;
  } seg_t;

  seg_t segs[$];
  int   first_low, lows;
  int   rep_pos[$];
  int   exp_rep[6] = '{7, 17, 22, 27, 32, 37};

  initial begin
    // bounce, press, release bounce, sub-threshold glitches, minimal accepted press
    for (int i = 0; i < 15; i++) begin
      segs.push_back('{1'b0, 2, 0, 1'b0, 1});
      segs.push_back('{1'b1, 2, 0, 1'b0, 1});
    end
    segs.push_back('{1'b1, 5,  0, 1'b0, 1});
    segs.push_back('{1'b0, 12, 1, 1'b1, 2});
    segs.push_back('{1'b1, 2,  0, 1'b1, 2});
    segs.push_back('{1'b0, 3,  0, 1'b1, 2});
    segs.push_back('{1'b1, 6,  0, 1'b1, 2});
    segs.push_back('{1'b1, 1,  0, 1'b0, 2});
    segs.push_back('{1'b0, 3,  0, 1'b0, 2});
    segs.push_back('{1'b1, 6,  0, 1'b0, 2});
    segs.push_back('{1'b0, 4,  0, 1'b0, 2});
    segs.push_back('{1'b1, 6,  0, 1'b0, 2});
    segs.push_back('{1'b0, 5,  0, 1'b0, 2});
    segs.push_back('{1'b1, 3,  1, 1'b1, 3});
    segs.push_back('{1'b1, 8,  0, 1'b0, 3});

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_step_n", step0, 1);
    check("reset_pressed", pressed0, 0);
    check("reset_count", cnt0, 0);
    rst = 1'b0;

    // Clean press: pulse 6 edges after first low sample (edge index 7 counting from 1)
    @(negedge clk);
    btn_n = 1'b0;
    first_low = -1; lows = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (!step0) begin lows++; if (first_low < 0) first_low = j; end
    end
    check("press_latency", first_low, 7);
    check("press_pulses", lows, 1);
    check("press_pressed", pressed0, 1);
    check("press_count", cnt0, 1);
    btn_n = 1'b1;
    repeat (10) @(negedge clk);
    check("release_pressed", pressed0, 0);

    // Table-driven segments
    foreach (segs[s]) begin
      btn_n = segs[s].btn;
      lows = 0;
      for (int j = 0; j < segs[s].cycles; j++) begin
        @(negedge clk);
        if (!step0) lows++;
      end
      check($sformatf("seg%0d_pulses", s), lows, segs[s].exp_lows);
      check($sformatf("seg%0d_pressed", s), pressed0, segs[s].exp_pressed);
      check($sformatf("seg%0d_count", s), cnt0, segs[s].exp_count);
    end

    // Auto-repeat: press pulse at T=7, repeats at T+10, +15, +20, +25, +30
    btn_n = 1'b0;
    lows = 0;
    for (int j = 1; j <= 38; j++) begin
      @(negedge clk);
      if (!step1) rep_pos.push_back(j);
      if (!step0) lows++;
    end
    check("repeat_n_pulses", rep_pos.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("repeat_pos%0d", i), (i < rep_pos.size()) ? rep_pos[i] : -1, exp_rep[i]);
    check("norepeat_pulses", lows, 1);
    check("repeat_count", cnt1, 4);
    btn_n = 1'b1;
    repeat (12) @(negedge clk);

    // Reset mid-hold
    btn_n = 1'b0;
    repeat (10) @(negedge clk);
    check("midhold_pressed_before", pressed0, 1);
    rst = 1'b1;
    #1;
    check("midrst_step_n", step0, 1);
    check("midrst_pressed", pressed0, 0);
    check("midrst_count", cnt0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    first_low = -1; lows = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (!step0) begin lows++; if (first_low < 0) first_low = j; end
    end
    check("postrst_latency", first_low, 7);
    check("postrst_pulses", lows, 1);
    check("postrst_count", cnt0, 1);
    btn_n = 1'b1;
    repeat (12) @(negedge clk);

    // 256 presses into the downstream FSM
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 256; p++) begin
      btn_n = 1'b0;
      repeat (8) @(negedge clk);
      btn_n = 1'b1;
      repeat (10) @(negedge clk);
    end
    check("wrap_count", cnt0, 0);
    check("wrap_count_rep", cnt1, 0);
    check("wrap_steps", steps_seen, 256);
    check("wrap_xyz", xyz, 0);
    check("wrap_pressed", pressed0, 0);
    check("no_back_to_back", back_to_back, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
